dm_access_arbiter: RTL and testbench
====================================

# dm_access_arbiter

Round-robin access arbiter that shares one single-port data-memory port between the four processor cores. It sequences a run from `start_process` to the point where all four cores have raised `end_process`. Each cycle it grants at most one core a read or write and returns read data to that core one cycle later. It sits between the four cores and a single-port data memory, and replaces per-core memory ports.

## Interface
Parameters:
- `AW`, 12: address width.
- `DW`, 17: write-data width (bus width).
- `RW`, 12: read-data width.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start_process`, in, 1: level; starts a run.
- `end_process`, in, 4: bit i is the done level of core i.
- `req`, in, 4: bit i means core i requests access. It is held until granted.
- `we`, in, 4: bit i selects write (1) or read (0) for core i.
- `addr0`..`addr3`, in, AW: per-core address.
- `wdata0`..`wdata3`, in, DW: per-core write data.
- `gnt`, out, 4: one-hot or zero; grant to core i in the current cycle.
- `mem_en`, out, 1: memory access this cycle.
- `mem_we`, out, 1: write strobe.
- `mem_addr`, out, AW: memory address.
- `mem_wdata`, out, DW: memory write data.
- `mem_rdata`, in, RW: memory read data, registered, valid one cycle after `mem_en & !mem_we`.
- `rvalid`, out, 4: one-hot; read data for core i is on `rdata`.
- `rdata`, out, RW: shared read-return bus; equals `mem_rdata`.
- `busy`, out, 1: high while in state RUN.
- `all_done`, out, 1: high in state DONE.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
  - IDLE → RUN when `start_process`=1.
  - RUN → DONE when the sticky done mask is 4'b1111.
  - DONE → IDLE when `start_process`=0, so each run needs a fresh start.
- Sticky done mask:
  - Cleared on the IDLE→RUN transition.
  - In RUN, bit i is set when `end_process[i]`=1.
  - Once set, bit i stays set until the next run even if the core drops `end_process`.
- Arbitration happens only in RUN; `gnt`=0 in IDLE and DONE.
  - Eligible cores are `req & ~done_mask`.
  - Grant goes to the first eligible core scanning from pointer `ptr`, in the order `ptr`, `ptr+1`, … modulo 4.
  - On a grant to core k, `ptr` ← (k+1) mod 4. With no grant, `ptr` holds.
- Memory drive is combinational from the granted index k:
  - `mem_en`=|`gnt`, `mem_we`=`we[k]`, `mem_addr`=`addrk`, `mem_wdata`=`wdatak`.
  - With no grant: `mem_en`=0, `mem_we`=0, and `mem_addr`/`mem_wdata` are 0.
- Read return: when a read is granted to core k, `rvalid[k]`=1 in the next cycle only. A write grant produces no `rvalid`.
- A core sees `gnt[i]` and must deassert or change `req[i]` in the following cycle. A `req` still high is treated as a new request.

## Timing
- Reset values:
  - state=IDLE, `ptr`=0, done mask=0.
  - `rvalid`=0, `busy`=0, `all_done`=0.
  - `gnt`=0 and `mem_en`=`mem_we`=0 (combinational, gated by state).
- Grant latency is 0 cycles: `gnt` is asserted in the cycle `req` is seen, if the core wins.
- Write commits at the clock edge ending the grant cycle.
- Read latency is 1 cycle from grant to `rvalid`.
- Worst-case wait for a continuously requesting core is 3 grant cycles (fairness bound).
- Simultaneous events:
  - If `end_process[i]` rises in the same cycle core i requests, the grant is still allowed in that cycle. The mask blocks core i from the next cycle.
  - If the last done bit arrives in the same cycle as a grant, the grant completes. The FSM enters DONE next cycle, and an `rvalid` owed from that read is still issued in DONE.
- Asynchronous reset in mid-run:
  - All registers return to reset values immediately, including a pending `rvalid` (dropped).
  - `gnt` and `mem_en` go low within the same cycle.
- `start_process` held high through DONE does not restart the run; it must drop first.

## Structure
- The shared package holds:
  - Constants `N_CORES`=4, `AW`, `DW`, `RW`.
  - The FSM state enum `arb_state_t` {IDLE, RUN, DONE}.
- Sub-module `rr_pick4` is combinational. It takes the eligible mask and `ptr` and produces a one-hot grant plus a 2-bit index. It is instantiated once.
- The FSM, done mask, `ptr` and read-return register live in `dm_access_arbiter`.

## Test plan
- Reset, then `start_process`=1 and core 2 writes addr 12'h010, data 17'h1ABCD → same-cycle `gnt`=4'b0100, `mem_we`=1, `mem_addr`=12'h010, `mem_wdata`=17'h1ABCD; `ptr`=3 next.
- All four cores request continuously from `ptr`=0 → `gnt` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- Core 1 reads addr 12'h020 while memory returns 12'h5A5 → `rvalid`=4'b0010 and `rdata`=12'h5A5 exactly one cycle after the grant; `rvalid` is 0 after a write grant.
- `end_process` bits rise one at a time (0, 3, 1, 2) with requests still active → done cores are never granted again; `all_done`=1 and `busy`=0 the cycle after bit 2. `start_process` low → IDLE, then high → RUN with the mask cleared.
- Read granted, `rst_n` pulled low before the next edge → `gnt`, `mem_en` and `rvalid` are 0 immediately; state IDLE, `ptr`=0 after release.
- Core 3 sets `end_process` while requesting in the same cycle → grant issued this cycle, not the next.

Source files
------------

// File: rtl/dm_access_arbiter_pkg.sv
// Shared constants and FSM state type for the data-memory access arbiter.
package dm_access_arbiter_pkg;

  localparam int N_CORES = 4;
  localparam int AW      = 12;
  localparam int DW      = 17;
  localparam int RW      = 12;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } arb_state_t;

endpackage

// File: rtl/dm_access_arbiter_if.sv
// Single-port data-memory bus: the arbiter is the master, the memory the slave.
interface dm_access_arbiter_if #(
  parameter int AW = dm_access_arbiter_pkg::AW,
  parameter int DW = dm_access_arbiter_pkg::DW,
  parameter int RW = dm_access_arbiter_pkg::RW
);

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [RW-1:0] mem_rdata;

  modport master (
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dm_access_arbiter_rr_pick4.sv
// Combinational round-robin picker: first eligible core scanning from ptr upward, mod 4.
module rr_pick4
  import dm_access_arbiter_pkg::*;
(
  input  logic [N_CORES-1:0] eligible,
  input  logic [1:0]         ptr,
  output logic [N_CORES-1:0] gnt,
  output logic [1:0]         idx
);

  logic       found;
  logic [1:0] cand;

  // Scan ptr, ptr+1, ... and take the first eligible core.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      cand = ptr + 2'(i);
      if (!found && eligible[cand]) begin
        found     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_access_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among four cores for one run.
module dm_access_arbiter
  import dm_access_arbiter_pkg::*;
#(
  parameter int AW = dm_access_arbiter_pkg::AW,
  parameter int DW = dm_access_arbiter_pkg::DW,
  parameter int RW = dm_access_arbiter_pkg::RW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_process,
  input  logic [N_CORES-1:0] end_process,
  input  logic [N_CORES-1:0] req,
  input  logic [N_CORES-1:0] we,
  input  logic [AW-1:0]      addr0,
  input  logic [AW-1:0]      addr1,
  input  logic [AW-1:0]      addr2,
  input  logic [AW-1:0]      addr3,
  input  logic [DW-1:0]      wdata0,
  input  logic [DW-1:0]      wdata1,
  input  logic [DW-1:0]      wdata2,
  input  logic [DW-1:0]      wdata3,
  output logic [N_CORES-1:0] gnt,
  dm_access_arbiter_if.master mem_bus,
  output logic [N_CORES-1:0] rvalid,
  output logic [RW-1:0]      rdata,
  output logic               busy,
  output logic               all_done
);

  arb_state_t         state;
  logic [1:0]         ptr;
  logic [N_CORES-1:0] done_mask;
  logic [N_CORES-1:0] done_next;
  logic [N_CORES-1:0] eligible;
  logic [N_CORES-1:0] pick_gnt;
  logic [1:0]         pick_idx;

  // A core raising end_process this cycle may still win this cycle; the mask blocks it afterwards.
  assign done_next = done_mask | end_process;
  assign eligible  = req & ~done_mask;
  assign rdata     = mem_bus.mem_rdata;

  rr_pick4 u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .gnt      (pick_gnt),
    .idx      (pick_idx)
  );

  // Grants exist only while running; gating by state makes them drop with async reset.
  always_comb begin
    gnt = '0;
    if (state == RUN) gnt = pick_gnt;
  end

  // Steer the granted core onto the memory port; the bus idles at zero otherwise.
  always_comb begin
    mem_bus.mem_en    = 1'b0;
    mem_bus.mem_we    = 1'b0;
    mem_bus.mem_addr  = '0;
    mem_bus.mem_wdata = '0;
    if (|gnt) begin
      mem_bus.mem_en = 1'b1;
      mem_bus.mem_we = we[pick_idx];
      case (pick_idx)
        2'd0:    begin mem_bus.mem_addr = addr0; mem_bus.mem_wdata = wdata0; end
        2'd1:    begin mem_bus.mem_addr = addr1; mem_bus.mem_wdata = wdata1; end
        2'd2:    begin mem_bus.mem_addr = addr2; mem_bus.mem_wdata = wdata2; end
        default: begin mem_bus.mem_addr = addr3; mem_bus.mem_wdata = wdata3; end
      endcase
    end
  end

  // Run sequencing with sticky done mask and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      done_mask <= '0;
      busy      <= 1'b0;
      all_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_process) begin
            state     <= RUN;
            done_mask <= '0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          done_mask <= done_next;
          if (done_next == '1) begin
            state    <= DONE;
            busy     <= 1'b0;
            all_done <= 1'b1;
          end
        end
        DONE: begin
          if (!start_process) begin
            state    <= IDLE;
            all_done <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          all_done <= 1'b0;
        end
      endcase
    end
  end

  // Advance the round-robin pointer past the winner; hold it when nobody is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else if (|gnt) ptr <= pick_idx + 2'd1;
  end

  // Flag the reading core one cycle after its grant, aligned with the memory's registered data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rvalid <= '0;
    else if ((|gnt) && !we[pick_idx]) rvalid <= gnt;
    else rvalid <= '0;
  end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench for dm_access_arbiter with a read-return scoreboard and a behavioural memory.
module tb_dm_access_arbiter;

  typedef struct {
    logic [3:0]  rv;
    logic [11:0] data;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_process;
  logic [3:0]  end_process;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [11:0] addr0, addr1, addr2, addr3;
  logic [16:0] wdata0, wdata1, wdata2, wdata3;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [11:0] rdata;
  logic        busy;
  logic        all_done;

  int checks = 0;
  int errors = 0;
  rd_exp_t exp_q[$];
  logic [11:0] mem [0:4095];

  dm_access_arbiter_if bus ();

  dm_access_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_process (start_process),
    .end_process   (end_process),
    .req           (req),
    .we            (we),
    .addr0         (addr0),
    .addr1         (addr1),
    .addr2         (addr2),
    .addr3         (addr3),
    .wdata0        (wdata0),
    .wdata1        (wdata1),
    .wdata2        (wdata2),
    .wdata3        (wdata3),
    .gnt           (gnt),
    .mem_bus       (bus),
    .rvalid        (rvalid),
    .rdata         (rdata),
    .busy          (busy),
    .all_done      (all_done)
  );

  always #5 clk = ~clk;

  // Single-port memory with registered read data; stores the low 12 bits of write data.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata[11:0];
      else bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the read return owed from the previous cycle, or require silence.
  task automatic chk_rv();
    rd_exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rvalid", {28'd0, rvalid}, {28'd0, e.rv});
      chk("rdata", {20'd0, rdata}, {20'd0, e.data});
    end else begin
      chk("rvalid_quiet", {28'd0, rvalid}, 32'd0);
    end
  endtask

  task automatic run_cycle(input logic [3:0] r, input logic [3:0] w, input logic [3:0] ep);
    @(posedge clk);
    #1;
    chk_rv();
    req         = r;
    we          = w;
    end_process = ep;
    #1;
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] g, input logic w,
                              input logic [11:0] a, input logic [11:0] rd);
    chk({tag, "_gnt"}, {28'd0, gnt}, {28'd0, g});
    chk({tag, "_mem_en"}, {31'd0, bus.mem_en}, {31'd0, |g});
    if (|g) begin
      chk({tag, "_mem_we"}, {31'd0, bus.mem_we}, {31'd0, w});
      chk({tag, "_mem_addr"}, {20'd0, bus.mem_addr}, {20'd0, a});
      if (!w) exp_q.push_back('{rv: g, data: rd});
    end else begin
      chk({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
      chk({tag, "_mem_addr"}, {20'd0, bus.mem_addr}, 32'd0);
      chk({tag, "_mem_wdata"}, {15'd0, bus.mem_wdata}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_process = 1'b0; end_process = '0; req = '0; we = '0;
    addr0 = 12'h100; addr1 = 12'h020; addr2 = 12'h010; addr3 = 12'h103;
    wdata0 = '0; wdata1 = '0; wdata2 = 17'h1ABCD; wdata3 = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h100] = 12'h111;
    mem[12'h020] = 12'h5A5;
    mem[12'h103] = 12'h333;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_rvalid", {28'd0, rvalid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_all_done", {31'd0, all_done}, 32'd0);
    rst_n = 1'b1;

    // Start the run; still IDLE this cycle.
    run_cycle(4'b0000, 4'b0000, 4'b0000);
    start_process = 1'b1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    expect_grant("idle", 4'b0000, 1'b0, 12'h000, 12'h000);

    // Core 2 write, granted in the same cycle.
    run_cycle(4'b0100, 4'b0100, 4'b0000);
    chk("run_busy", {31'd0, busy}, 32'd1);
    expect_grant("wr2", 4'b0100, 1'b1, 12'h010, 12'h000);
    chk("wr2_wdata", {15'd0, bus.mem_wdata}, {15'd0, 17'h1ABCD});

    // ptr is 3 after the write; all four cores read continuously.
    run_cycle(4'b1111, 4'b0000, 4'b0000);
    expect_grant("rr3", 4'b1000, 1'b0, 12'h103, 12'h333);
    run_cycle(4'b1111, 4'b0000, 4'b0000);
    expect_grant("rr0", 4'b0001, 1'b0, 12'h100, 12'h111);
    run_cycle(4'b1111, 4'b0000, 4'b0000);
    expect_grant("rr1", 4'b0010, 1'b0, 12'h020, 12'h5A5);
    run_cycle(4'b1111, 4'b0000, 4'b0000);
    expect_grant("rr2", 4'b0100, 1'b0, 12'h010, 12'hBCD);
    run_cycle(4'b1111, 4'b0000, 4'b0000);
    expect_grant("rr3b", 4'b1000, 1'b0, 12'h103, 12'h333);
    run_cycle(4'b1111, 4'b0000, 4'b0000);
    expect_grant("rr0b", 4'b0001, 1'b0, 12'h100, 12'h111);

    // Done bits arrive in order 0, 3, 1, 2; earlier bits are dropped but stay sticky.
    run_cycle(4'b1111, 4'b0000, 4'b0001);
    expect_grant("d0", 4'b0010, 1'b0, 12'h020, 12'h5A5);
    run_cycle(4'b1111, 4'b0000, 4'b1000);
    expect_grant("d3", 4'b0100, 1'b0, 12'h010, 12'hBCD);
    run_cycle(4'b1111, 4'b0000, 4'b0010);
    expect_grant("d1", 4'b0010, 1'b0, 12'h020, 12'h5A5);
    run_cycle(4'b1111, 4'b0000, 4'b0100);
    expect_grant("d2", 4'b0100, 1'b0, 12'h010, 12'hBCD);
    chk("d2_busy", {31'd0, busy}, 32'd1);
    chk("d2_all_done", {31'd0, all_done}, 32'd0);

    // DONE: owed read still returned, no grants, start held high does not restart.
    run_cycle(4'b1111, 4'b0000, 4'b0000);
    chk("done_all_done", {31'd0, all_done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    expect_grant("done", 4'b0000, 1'b0, 12'h000, 12'h000);
    run_cycle(4'b1111, 4'b0000, 4'b0000);
    chk("done_hold", {31'd0, all_done}, 32'd1);
    expect_grant("done_hold", 4'b0000, 1'b0, 12'h000, 12'h000);
    start_process = 1'b0;

    run_cycle(4'b0000, 4'b0000, 4'b0000);
    chk("idle2_all_done", {31'd0, all_done}, 32'd0);
    chk("idle2_busy", {31'd0, busy}, 32'd0);
    start_process = 1'b1;

    // New run with cleared mask; core 3 finishes in the cycle it is granted.
    run_cycle(4'b1000, 4'b0000, 4'b1000);
    chk("run2_busy", {31'd0, busy}, 32'd1);
    expect_grant("same3", 4'b1000, 1'b0, 12'h103, 12'h333);
    run_cycle(4'b1001, 4'b0000, 4'b0000);
    expect_grant("masked3", 4'b0001, 1'b0, 12'h100, 12'h111);

    // Read granted, then async reset before the next edge.
    run_cycle(4'b0010, 4'b0000, 4'b0000);
    expect_grant("rd_rst", 4'b0010, 1'b0, 12'h020, 12'h5A5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", {28'd0, gnt}, 32'd0);
    chk("arst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("arst_rvalid", {28'd0, rvalid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    run_cycle(4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b1;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // ptr back at 0 after reset: core 0 wins first.
    run_cycle(4'b1111, 4'b0000, 4'b0000);
    chk("post_rst_run", {31'd0, busy}, 32'd1);
    expect_grant("post_rst", 4'b0001, 1'b0, 12'h100, 12'h111);
    run_cycle(4'b0000, 4'b0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
